// File: rtl/uart_framer_pkg.sv
// Shared types for the UART frame transmitter: controller states, frame field
// selector and the default frame start marker.
package uart_framer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT
    } state_e;

    typedef enum logic [1:0] {
        FLD_SYNC,
        FLD_LEN,
        FLD_PAY,
        FLD_CSUM
    } field_e;

    localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/uart_frame_checksum.sv
// Running XOR over the bytes of a frame; cleared at frame acceptance and
// updated once per acknowledged byte.
module uart_frame_checksum (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       clr_i,
    input  logic       en_i,
    input  logic [7:0] data_i,
    output logic [7:0] acc_o
);

    logic [7:0] acc_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= 8'h00;
        end else if (clr_i) begin
            acc_q <= 8'h00;
        end else if (en_i) begin
            acc_q <= acc_q ^ data_i;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/uart_tx_framer.sv
// Frame transmitter: [SYNC][LEN] payload [CSUM], one byte per uart_tx
// handshake (tx_dv out, tx_done back), with length validation.
module uart_tx_framer
    import uart_framer_pkg::*;
#(
    parameter int unsigned MAX_BYTES   = 16,
    parameter int unsigned LEN_WIDTH   = 8,
    parameter bit          HEADER_EN   = 1'b1,
    parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
    parameter bit          CHECKSUM_EN = 1'b1
) (
    input  logic                   CLK,
    input  logic                   RST_N,
    input  logic                   chunk_valid,
    input  logic [LEN_WIDTH-1:0]   chunk_length,
    input  logic [MAX_BYTES*8-1:0] chunk_bytes,
    output logic                   chunk_ready,
    output logic                   busy,
    output logic                   tx_dv,
    output logic [7:0]             tx_data,
    input  logic                   tx_done,
    output logic                   frame_done,
    output logic                   frame_error
);

    localparam field_e FIRST_FIELD = HEADER_EN ? FLD_SYNC : FLD_PAY;

    state_e                 state_q;
    field_e                 field_q;
    logic [LEN_WIDTH-1:0]   idx_q;
    logic [LEN_WIDTH-1:0]   len_q;
    logic [MAX_BYTES*8-1:0] bytes_q;
    logic                   ready_q;
    logic                   busy_q;
    logic                   tx_dv_q;
    logic [7:0]             tx_data_q;
    logic                   frame_done_q;
    logic                   frame_error_q;

    logic                   len_ok;
    logic                   csum_clr;
    logic                   csum_en;
    logic [7:0]             csum_acc;
    logic [7:0]             len_byte;
    logic [LEN_WIDTH-1:0]   nxt_idx;
    field_e                 adv_field_d;
    logic [LEN_WIDTH-1:0]   adv_idx_d;
    logic [7:0]             adv_data_d;
    logic                   adv_end_d;

    assign len_ok   = (chunk_length != '0) && (chunk_length <= LEN_WIDTH'(MAX_BYTES));
    assign len_byte = 8'(len_q);
    assign nxt_idx  = idx_q + LEN_WIDTH'(1);
    assign csum_clr = (state_q == ST_IDLE) && chunk_valid && len_ok;
    assign csum_en  = (state_q == ST_WAIT) && tx_done
                      && ((field_q == FLD_LEN) || (field_q == FLD_PAY));

    uart_frame_checksum u_checksum (
        .clk    (CLK),
        .rst_n  (RST_N),
        .clr_i  (csum_clr),
        .en_i   (csum_en),
        .data_i (tx_data_q),
        .acc_o  (csum_acc)
    );

    // The checksum byte is issued on the same edge the last payload byte is
    // folded in, so it is taken from the accumulator's next value.
    always_comb begin
        adv_field_d = field_q;
        adv_idx_d   = idx_q;
        adv_data_d  = tx_data_q;
        adv_end_d   = 1'b0;
        case (field_q)
            FLD_SYNC: begin
                adv_field_d = FLD_LEN;
                adv_data_d  = len_byte;
            end
            FLD_LEN: begin
                adv_field_d = FLD_PAY;
                adv_idx_d   = '0;
                adv_data_d  = bytes_q[7:0];
            end
            FLD_PAY: begin
                if (nxt_idx < len_q) begin
                    adv_idx_d  = nxt_idx;
                    adv_data_d = bytes_q[{nxt_idx, 3'b000} +: 8];
                end else if (CHECKSUM_EN) begin
                    adv_field_d = FLD_CSUM;
                    adv_data_d  = csum_acc ^ tx_data_q;
                end else begin
                    adv_end_d = 1'b1;
                end
            end
            default: adv_end_d = 1'b1;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q       <= ST_IDLE;
            field_q       <= FLD_SYNC;
            idx_q         <= '0;
            len_q         <= '0;
            bytes_q       <= '0;
            ready_q       <= 1'b1;
            busy_q        <= 1'b0;
            tx_dv_q       <= 1'b0;
            tx_data_q     <= 8'h00;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
        end else begin
            tx_dv_q       <= 1'b0;
            frame_done_q  <= 1'b0;
            frame_error_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (chunk_valid) begin
                        bytes_q <= chunk_bytes;
                        len_q   <= chunk_length;
                        if (!len_ok) begin
                            frame_error_q <= 1'b1;
                        end else begin
                            field_q   <= FIRST_FIELD;
                            idx_q     <= '0;
                            tx_data_q <= HEADER_EN ? SYNC_BYTE : chunk_bytes[7:0];
                            tx_dv_q   <= 1'b1;
                            ready_q   <= 1'b0;
                            busy_q    <= 1'b1;
                            state_q   <= ST_ISSUE;
                        end
                    end
                end
                ST_ISSUE: state_q <= ST_WAIT;
                ST_WAIT: begin
                    if (tx_done) begin
                        if (adv_end_d) begin
                            frame_done_q <= 1'b1;
                            ready_q      <= 1'b1;
                            busy_q       <= 1'b0;
                            state_q      <= ST_IDLE;
                        end else begin
                            field_q   <= adv_field_d;
                            idx_q     <= adv_idx_d;
                            tx_data_q <= adv_data_d;
                            tx_dv_q   <= 1'b1;
                            state_q   <= ST_ISSUE;
                        end
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign chunk_ready = ready_q;
    assign busy        = busy_q;
    assign tx_dv       = tx_dv_q;
    assign tx_data     = tx_data_q;
    assign frame_done  = frame_done_q;
    assign frame_error = frame_error_q;

endmodule

// File: tb/tb_uart_tx_framer.sv
// Bench for uart_tx_framer: a default instance and a bare-payload instance
// (no header, no checksum), driven by directed and random frames.
module tb_uart_tx_framer;

    logic         CLK = 1'b0;
    logic         RST_N = 1'b0;
    logic [1:0]   cv;
    logic [7:0]   clen;
    logic [127:0] cbytes;
    logic [1:0]   tdone;
    logic [1:0]   ready, busy, dv, fdone, ferr;
    logic [7:0]   tdata [2];

    int n_assert = 0;
    int n_fail   = 0;
    logic [7:0] exp_q[$];

    always #5 CLK = ~CLK;

    uart_tx_framer dut0 (
        .CLK(CLK), .RST_N(RST_N), .chunk_valid(cv[0]), .chunk_length(clen),
        .chunk_bytes(cbytes), .chunk_ready(ready[0]), .busy(busy[0]),
        .tx_dv(dv[0]), .tx_data(tdata[0]), .tx_done(tdone[0]),
        .frame_done(fdone[0]), .frame_error(ferr[0])
    );

    uart_tx_framer #(.HEADER_EN(1'b0), .CHECKSUM_EN(1'b0)) dut1 (
        .CLK(CLK), .RST_N(RST_N), .chunk_valid(cv[1]), .chunk_length(clen),
        .chunk_bytes(cbytes), .chunk_ready(ready[1]), .busy(busy[1]),
        .tx_dv(dv[1]), .tx_data(tdata[1]), .tx_done(tdone[1]),
        .frame_done(fdone[1]), .frame_error(ferr[1])
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Reference frame: instance 0 has header and checksum, instance 1 payload only.
    task automatic build_exp(input int sel, input int len, input logic [127:0] b);
        logic [7:0] x;
        exp_q.delete();
        x = 8'h00;
        if (sel == 0) begin
            exp_q.push_back(8'hA5);
            exp_q.push_back(8'(len));
            x = 8'(len);
        end
        for (int i = 0; i < len; i++) begin
            exp_q.push_back(b[8*i +: 8]);
            x = x ^ b[8*i +: 8];
        end
        if (sel == 0) exp_q.push_back(x);
    endtask

    task automatic check_reset_outputs(input int sel);
        check("rst_ready", ready[sel], 1);
        check("rst_busy", busy[sel], 0);
        check("rst_dv", dv[sel], 0);
        check("rst_data", tdata[sel], 0);
        check("rst_fdone", fdone[sel], 0);
        check("rst_ferr", ferr[sel], 0);
    endtask

    // Sends one request and plays the uart_tx side. abort_at >= 0 asserts
    // reset while that byte index is being issued.
    task automatic send(input int sel, input int len, input logic [127:0] b, input int abort_at);
        int n;
        logic [7:0] held;
        cv[sel] = 1'b1;
        clen    = 8'(len);
        cbytes  = b;
        step();
        cv[sel] = 1'b0;
        clen    = 8'($urandom);
        cbytes  = {$urandom, $urandom, $urandom, $urandom};
        check("accept_fdone_low", fdone[sel], 0);
        if (len == 0 || len > 16) begin
            check("rej_error", ferr[sel], 1);
            check("rej_ready", ready[sel], 1);
            check("rej_dv", dv[sel], 0);
            step();
            check("rej_error_pulse", ferr[sel], 0);
            check("rej_ready2", ready[sel], 1);
            check("rej_dv2", dv[sel], 0);
            $display("frame sel=%0d len=%0d rejected", sel, len);
            return;
        end
        check("acc_ready_low", ready[sel], 0);
        check("acc_busy", busy[sel], 1);
        check("acc_no_error", ferr[sel], 0);
        build_exp(sel, len, b);
        n = exp_q.size();
        for (int k = 0; k < n; k++) begin
            check("dv_issue", dv[sel], 1);
            check("tx_byte", tdata[sel], exp_q[k]);
            if (k == abort_at) begin
                #2 RST_N = 1'b0;
                #1;
                check_reset_outputs(sel);
                step();
                step();
                check("rst_hold_dv", dv[sel], 0);
                check("rst_hold_fdone", fdone[sel], 0);
                $display("frame sel=%0d len=%0d aborted by reset at byte %0d", sel, len, k);
                return;
            end
            held = tdata[sel];
            if ($urandom_range(0, 2) == 0) tdone[sel] = 1'b1;
            step();
            tdone[sel] = 1'b0;
            check("dv_one_cycle", dv[sel], 0);
            check("data_stable", tdata[sel], held);
            repeat ($urandom_range(0, 3)) begin
                if ($urandom_range(0, 1) == 1) begin
                    cv[sel] = 1'b1;
                    clen    = 8'($urandom_range(0, 20));
                end
                step();
                cv[sel] = 1'b0;
                check("wait_dv", dv[sel], 0);
                check("data_stable", tdata[sel], held);
                check("wait_fdone", fdone[sel], 0);
            end
            tdone[sel] = 1'b1;
            step();
            tdone[sel] = 1'b0;
        end
        check("frame_done", fdone[sel], 1);
        check("end_ready", ready[sel], 1);
        check("end_busy", busy[sel], 0);
        check("end_dv", dv[sel], 0);
        $display("frame sel=%0d len=%0d bytes=%0d done", sel, len, n);
    endtask

    initial begin
        logic [127:0] rb;
        int sel;
        int len;
        cv = 2'b00;
        tdone = 2'b00;
        clen = 8'h00;
        cbytes = '0;
        #12;
        check_reset_outputs(0);
        check_reset_outputs(1);
        step();
        RST_N = 1'b1;
        step();

        send(0, 3, 128'h332211, -1);
        send(1, 1, 128'h7F, -1);
        send(0, 0, 128'h55, -1);
        send(0, 17, 128'h55, -1);
        send(1, 0, 128'h55, -1);
        send(0, 16, {128{1'b1}}, -1);
        send(0, 3, {$urandom, $urandom, $urandom, $urandom}, -1);

        send(0, 4, {$urandom, $urandom, $urandom, $urandom}, 3);
        RST_N = 1'b1;
        step();
        send(0, 2, 128'hC3B2, -1);

        for (int t = 0; t < 20; t++) begin
            sel = int'($urandom_range(0, 1));
            if ($urandom_range(0, 7) == 0) len = ($urandom_range(0, 1) == 0) ? 0 : 17;
            else len = int'($urandom_range(1, 16));
            rb = {$urandom, $urandom, $urandom, $urandom};
            send(sel, len, rb, -1);
            if ($urandom_range(0, 1) == 1) step();
        end

        step();
        check("final_fdone0", fdone[0], 0);
        check("final_fdone1", fdone[1], 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
